// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - presents a (r-1, r, r+1) row window read from BRAM over a valid/ready handshake
// Define LINE_WINDOW_WRAP_EN for toroidal borders; zero-padded borders otherwise.
module line_window_buffer #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int ROW_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             fetch_en,
  output logic [ROW_W-1:0] fetch_addr,
  input  logic [WIDTH-1:0] fetch_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] middle,
  output logic [WIDTH-1:0] bottom,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W:0]    HEIGHT_W  = (ROW_W + 1)'(HEIGHT);
  localparam logic [RD_LAT-1:0] PEND_LAST = RD_LAT'(1 << (RD_LAT - 1));
`ifdef LINE_WINDOW_WRAP_EN
  localparam logic [1:0] PRIME_FIRST = 2'd0;
`else
  localparam logic [1:0] PRIME_FIRST = 2'd1;
`endif

  state_t             state_q, state_d;
  logic               fetch_en_q, fetch_en_d;
  logic [ROW_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [RD_LAT-1:0]  pend_q, pend_d;
  logic [ROW_W:0]     next_row_q, next_row_d;
  logic [1:0]         prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d, stg_q, stg_d;
  logic               stg_full_q, stg_full_d;
  logic               out_valid_q, out_valid_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               cap, hs, rd_free, need_stg;
  logic [WIDTH-1:0]   edge_row;

`ifdef LINE_WINDOW_WRAP_EN
  logic [WIDTH-1:0]   wrap_q, wrap_d;
  assign edge_row = wrap_q;
`else
  assign edge_row = '0;
`endif

  // pend_q[i] high means a read issued i+1 cycles ago; the top bit marks data arriving now
  assign cap      = pend_q[RD_LAT-1];
  assign hs       = out_valid_q && out_ready;
  assign rd_free  = !fetch_en_q && ((pend_q & ~PEND_LAST) == '0);
  assign need_stg = ({1'b0, out_row_q} + (ROW_W + 1)'(2)) < HEIGHT_W;

  always_comb begin
    state_d      = state_q;
    fetch_en_d   = 1'b0;
    fetch_addr_d = fetch_addr_q;
    pend_d       = RD_LAT'({pend_q, fetch_en_q});
    next_row_d   = next_row_q;
    prime_cnt_d  = prime_cnt_q;
    top_d        = top_q;
    mid_d        = mid_q;
    bot_d        = bot_q;
    stg_d        = stg_q;
    stg_full_d   = stg_full_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
`ifdef LINE_WINDOW_WRAP_EN
    wrap_d       = wrap_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PRIME;
          top_d       = '0;
          mid_d       = '0;
          bot_d       = '0;
          stg_full_d  = 1'b0;
          out_row_d   = '0;
          next_row_d  = '0;
          prime_cnt_d = PRIME_FIRST;
        end
      end
      PRIME: begin
        if (cap) begin
          prime_cnt_d = prime_cnt_q + 2'd1;
          case (prime_cnt_q)
            2'd0: top_d = fetch_data;
            2'd1: begin
              mid_d = fetch_data;
`ifdef LINE_WINDOW_WRAP_EN
              wrap_d = fetch_data;
`endif
            end
            default: begin
              bot_d       = fetch_data;
              state_d     = RUN;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        if (hs) begin
          if (out_row_q == LAST_ROW) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            top_d       = '0;
            mid_d       = '0;
            bot_d       = '0;
            out_row_d   = '0;
          end else begin
            top_d     = mid_q;
            mid_d     = bot_q;
            out_row_d = out_row_q + 1'b1;
            if (!need_stg) begin
              bot_d = edge_row;
            end else if (stg_full_q) begin
              bot_d      = stg_q;
              stg_full_d = 1'b0;
            end else if (cap) begin
              bot_d = fetch_data;
            end else begin
              out_valid_d = 1'b0;
            end
          end
        end else if (cap) begin
          // an invalid window is only ever waiting on its bottom row
          if (!out_valid_q) begin
            bot_d       = fetch_data;
            out_valid_d = 1'b1;
          end else begin
            stg_d      = fetch_data;
            stg_full_d = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (rd_free && (next_row_d < HEIGHT_W) &&
        (state_d == PRIME || (state_d == RUN && !stg_full_d))) begin
      fetch_en_d = 1'b1;
`ifdef LINE_WINDOW_WRAP_EN
      if (state_q == IDLE) begin
        fetch_addr_d = LAST_ROW;
      end else begin
        fetch_addr_d = next_row_d[ROW_W-1:0];
        next_row_d   = next_row_d + 1'b1;
      end
`else
      fetch_addr_d = next_row_d[ROW_W-1:0];
      next_row_d   = next_row_d + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_en_q   <= 1'b0;
      fetch_addr_q <= '0;
      pend_q       <= '0;
      next_row_q   <= '0;
      prime_cnt_q  <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      stg_q        <= '0;
      stg_full_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
`ifdef LINE_WINDOW_WRAP_EN
      wrap_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_en_q   <= fetch_en_d;
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= pend_d;
      next_row_q   <= next_row_d;
      prime_cnt_q  <= prime_cnt_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      stg_q        <= stg_d;
      stg_full_q   <= stg_full_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
`ifdef LINE_WINDOW_WRAP_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

  assign busy       = (state_q == PRIME) || (state_q == RUN);
  assign frame_done = (state_q == DONE);
  assign fetch_en   = fetch_en_q;
  assign fetch_addr = fetch_addr_q;
  assign top        = top_q;
  assign middle     = mid_q;
  assign bottom     = bot_q;
  assign out_row    = out_row_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q && (out_row_q == LAST_ROW);

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - self-checking bench for line_window_buffer at RD_LAT 1 and 3
// Honours LINE_WINDOW_WRAP_EN to select the toroidal reference model.
module tb_line_window_buffer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int RW = 2;
`ifdef LINE_WINDOW_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  bit   sel;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [W-1:0] mem [H];

  logic          busy_w [2], done_w [2], fen_w [2], last_w [2], valid_w [2];
  logic [RW-1:0] faddr_w [2], row_w [2];
  logic [W-1:0]  fdata_w [2], top_w [2], mid_w [2], bot_w [2];

  logic          c_busy, c_done, c_fen, c_last, c_valid;
  logic [RW-1:0] c_faddr, c_row;
  logic [W-1:0]  c_top, c_mid, c_bot;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = (k == 0) ? 1 : 3;
    logic [W-1:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= fen_w[k] ? mem[faddr_w[k]] : W'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fdata_w[k] = pipe[LAT-1];

    line_window_buffer #(.WIDTH(W), .HEIGHT(H), .ROW_W(RW), .RD_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start && (sel == k)),
      .busy       (busy_w[k]),
      .frame_done (done_w[k]),
      .fetch_en   (fen_w[k]),
      .fetch_addr (faddr_w[k]),
      .fetch_data (fdata_w[k]),
      .top        (top_w[k]),
      .middle     (mid_w[k]),
      .bottom     (bot_w[k]),
      .out_row    (row_w[k]),
      .out_last   (last_w[k]),
      .out_valid  (valid_w[k]),
      .out_ready  (ready)
    );
  end

  always_comb begin
    c_busy  = busy_w[sel];
    c_done  = done_w[sel];
    c_fen   = fen_w[sel];
    c_last  = last_w[sel];
    c_valid = valid_w[sel];
    c_faddr = faddr_w[sel];
    c_row   = row_w[sel];
    c_top   = top_w[sel];
    c_mid   = mid_w[sel];
    c_bot   = bot_w[sel];
  end

  task automatic fill_pattern();
    for (int i = 0; i < H; i++) mem[i] = W'(8'h11 * (i + 1));
  endtask

  task automatic fill_random();
    for (int i = 0; i < H; i++) mem[i] = W'($urandom);
  endtask

  // One full frame on the selected instance, checked against the row-window model.
  task automatic run_frame(input int stall_row, input int stall_len, input bit rand_ready,
                           input int start_row, input bit start_on_done);
    logic [W-1:0] et [H];
    logic [W-1:0] em [H];
    logic [W-1:0] eb [H];
    int exp_addr [$];
    int fa [$];
    int fc [$];
    int lat_rd, lat_exp, h, ts, stall_cnt, done_cnt, stall_fetch, stall_addr;
    bit first, resume_chk, finished;
    lat_rd  = sel ? 3 : 1;
    lat_exp = (WRAP ? 3 : 2) * (lat_rd + 1) + 1;
    for (int r = 0; r < H; r++) begin
      em[r] = mem[r];
      et[r] = (r == 0)     ? (WRAP ? mem[H-1] : '0) : mem[r-1];
      eb[r] = (r == H - 1) ? (WRAP ? mem[0]   : '0) : mem[r+1];
    end
    if (WRAP) exp_addr.push_back(H - 1);
    for (int r = 0; r < H; r++) exp_addr.push_back(r);
    h = 0; ts = 0; stall_cnt = 0; done_cnt = 0; stall_fetch = 0; stall_addr = -1;
    first = 1; resume_chk = 0; finished = 0;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int guard = 0; guard < 300 && !finished; guard++) begin
      @(negedge clk);
      start = 1'b0;
      if (guard == 0) ts = cyc;
      if (c_fen) begin
        fa.push_back(int'(c_faddr));
        fc.push_back(cyc);
        if (c_valid && c_row == 1) begin
          stall_fetch++;
          stall_addr = int'(c_faddr);
        end
      end
      if (c_done) done_cnt++;
      if (resume_chk) begin
        resume_chk = 0;
        n_chk++;
        if (!(c_valid === 1'b1 && c_row == 2)) begin
          n_fail++;
          $display("FAIL resume: valid=%0b row=%0d, required valid=1 row=2", c_valid, c_row);
        end
      end
      if (h == H) begin
        n_chk++;
        if ({c_done, c_busy, c_valid} !== 3'b100) begin
          n_fail++;
          $display("FAIL frame_end: done/busy/valid=%03b, required 100", {c_done, c_busy, c_valid});
        end
        if (start_on_done) start = 1'b1;
        finished = 1;
      end else begin
        n_chk++;
        if (c_busy !== 1'b1 || c_done !== 1'b0) begin
          n_fail++;
          $display("FAIL busy: busy=%0b done=%0b at window %0d, required busy=1 done=0", c_busy, c_done, h);
        end
        if (c_valid) begin
          if (first) begin
            first = 0;
            n_chk++;
            if (cyc - ts + 1 != lat_exp) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - ts + 1, lat_exp);
            end
          end
          n_chk++;
          if (int'(c_row) != h ||
              {c_top, c_mid, c_bot, c_last} !== {et[h], em[h], eb[h], (h == H - 1)}) begin
            n_fail++;
            $display("FAIL window: row=%0d t/m/b=%h/%h/%h last=%0b, required row=%0d %h/%h/%h last=%0b",
                     c_row, c_top, c_mid, c_bot, c_last, h, et[h], em[h], eb[h], (h == H - 1));
          end
          if (int'(c_row) == stall_row && stall_cnt < stall_len) begin
            ready = 1'b0;
            stall_cnt++;
          end else begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (int'(c_row) == start_row) start = 1'b1;
          if (ready) begin
            if (h == stall_row && stall_len > 0) resume_chk = 1;
            h++;
          end
        end else begin
          ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    end
    ready = 1'b1;
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: frame incomplete after %0d windows, required %0d", h, H);
    end
    if (start_on_done) begin
      @(negedge clk);
      start = 1'b0;
      n_chk++;
      if (c_busy !== 1'b0 || c_valid !== 1'b0 || c_fen !== 1'b0) begin
        n_fail++;
        $display("FAIL start_on_done: busy=%0b valid=%0b fetch_en=%0b, required all 0", c_busy, c_valid, c_fen);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (c_done) done_cnt++;
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d frame_done pulses, required 1", done_cnt);
    end
    n_chk++;
    if (fa.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL fetch_count: got %0d, required %0d", fa.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < fa.size(); i++) begin
        n_chk++;
        if (fa[i] != exp_addr[i]) begin
          n_fail++;
          $display("FAIL fetch_addr[%0d]: got %0d, required %0d", i, fa[i], exp_addr[i]);
        end
        if (i > 0) begin
          n_chk++;
          if (fc[i] - fc[i-1] < lat_rd + 1) begin
            n_fail++;
            $display("FAIL fetch_gap[%0d]: got %0d cycles, required >= %0d", i, fc[i] - fc[i-1], lat_rd + 1);
          end
        end
      end
    end
    if (stall_len > 0) begin
      n_chk++;
      if (stall_fetch != 1 || stall_addr != 3) begin
        n_fail++;
        $display("FAIL stall_prefetch: got %0d fetches (addr %0d), required 1 (addr 3)", stall_fetch, stall_addr);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      sel = 1'(k);
      #1;
      n_chk++;
      if ({c_busy, c_done, c_fen, c_faddr, c_top, c_mid, c_bot, c_row, c_last, c_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: busy=%0b done=%0b fen=%0b valid=%0b t/m/b=%h/%h/%h, required all 0",
                 k, c_busy, c_done, c_fen, c_valid, c_top, c_mid, c_bot);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_dead_border();
    sel = 1'b0;
    fill_pattern();
    run_frame(-1, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    fill_pattern();
    run_frame(1, 10, 1'b0, -1, 1'b0);
  endtask

  task automatic test_latency_sweep();
    sel = 1'b1;
    fill_pattern();
    run_frame(-1, 0, 1'b0, -1, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_start_during_busy();
    sel = 1'b0;
    fill_random();
    run_frame(-1, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    fill_random();
    run_frame(-1, 0, 1'b0, -1, 1'b1);
    fill_random();
    run_frame(-1, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit bad;
    sel = 1'b0;
    fill_random();
    ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (c_valid && c_row == 2) seen = 1;
      else @(negedge clk);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_mid_reach: row 2 never presented, required within 100 cycles");
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({c_busy, c_done, c_fen, c_faddr, c_top, c_mid, c_bot, c_row, c_last, c_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%0b valid=%0b row=%0d t/m/b=%h/%h/%h, required all 0",
               c_busy, c_valid, c_row, c_top, c_mid, c_bot);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (c_done || c_busy || c_valid || c_fen) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: activity after reset, required none");
    end
    fill_random();
    run_frame(-1, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 6; i++) begin
      sel = 1'(i % 2);
      fill_random();
      run_frame(-1, 0, 1'b1, -1, 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    sel   = 1'b0;
    for (int i = 0; i < H; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_dead_border();
    test_backpressure();
    test_latency_sweep();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised successor to the single-size line buffer, feeding the Game-of-Life next-state engine.
- For each output row r of a frame, reads board rows from BRAM and presents a three-row window (r-1, r, r+1).
- Uses a valid/ready handshake toward the consumer.
- Supports configurable width, height and BRAM read latency, with zero-padded borders by default.

Parameters:
- WIDTH, 1280, cells per row (row bit width).
- HEIGHT, 720, rows per frame; legal range 3..2**ROW_W.
- ROW_W, 10, row index / address width.
- RD_LAT, 1, BRAM read latency in cycles (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after last window handshake.
- fetch_en  out  1  BRAM read strobe.
- fetch_addr  out  ROW_W  BRAM row address, valid with fetch_en.
- fetch_data  in  WIDTH  BRAM read data, valid RD_LAT cycles after fetch_en.
- top  out  WIDTH  row r-1.
- middle  out  WIDTH  row r.
- bottom  out  WIDTH  row r+1.
- out_row  out  ROW_W  index r of the presented window.
- out_last  out  1  high with out_valid when r == HEIGHT-1.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.

Behaviour:
- Reset state: all outputs 0; state IDLE; staging register empty; pending-read shift register cleared.
- Reset asserted mid-frame aborts the frame with no frame_done. Returning reads are discarded.
- FSM states: IDLE, PRIME, RUN, DONE.
- IDLE:
  - start=1 -> PRIME, busy=1.
  - start while busy is ignored.
- PRIME:
  - top<=0.
  - Fetch row 0 into middle, then row 1 into bottom.
  - One read outstanding at a time: issue, wait RD_LAT, capture.
  - -> RUN with out_valid=1, out_row=0.
  - Latency from start to first out_valid: 2*(RD_LAT+1)+1 cycles.
- RUN:
  - out_valid held with all window outputs stable until out_valid&&out_ready.
  - While waiting, prefetch row out_row+2 (if <= HEIGHT-1) into a one-deep staging register.
  - On handshake:
    - top<=middle, middle<=bottom.
    - bottom<=staging, or 0 when out_row+2 > HEIGHT-1.
    - out_row increments.
  - If staging is required but not yet filled, out_valid drops to 0 until data arrives. Windows are never presented with stale data.
  - Handshake while out_last=1 -> DONE.
- DONE: frame_done=1 for one cycle, busy=0, out_valid=0, -> IDLE.
- Fetch rules:
  - Never address >= HEIGHT.
  - Exactly HEIGHT reads per frame, each row read once, in ascending order.
  - fetch_addr holds its last value when fetch_en=0.
- out_ready may be held high continuously.
- Maximum throughput is one window per RD_LAT+1 cycles.
- Boundary cases:
  - Row 0: top=0.
  - Row HEIGHT-1: bottom=0.
  - Row HEIGHT-2: bottom = row HEIGHT-1, no further fetch.
- start in the same cycle as frame_done: ignored. A new start is accepted from IDLE only.

Optional Feature:
- Macro LINE_WINDOW_WRAP_EN enables toroidal boundary.
- With the macro:
  - Row 0 top = row HEIGHT-1.
  - Row HEIGHT-1 bottom = row 0.
  - PRIME fetches rows HEIGHT-1, 0, 1, so latency is 3*(RD_LAT+1)+1.
  - Row 0 contents are retained in a dedicated wrap register for the final window.
  - Total reads per frame = HEIGHT+1.
- Without the macro: zero-padded borders as above, and no wrap register is synthesised.

Test Plan:
- Dead-border frame: WIDTH=8, HEIGHT=4, RD_LAT=1, row i = 8'h11*(i+1), out_ready=1.
  - Windows expected: (00,11,22), (11,22,33), (22,33,44), (33,44,00).
  - out_last only on row 3; frame_done 1 cycle after the final handshake; exactly 4 fetches, addresses 0..3.
- Backpressure: same config, out_ready=0 for 10 cycles at row 1.
  - Window stays (11,22,33) and stable; exactly one prefetch (addr 3) issued during the stall.
  - Resumes with (22,33,44) on the cycle after ready.
- Latency sweep: RD_LAT=3.
  - First out_valid 9 cycles after start; windows identical to the first scenario.
  - No fetch_en while a read is pending.
- Wrap mode (LINE_WINDOW_WRAP_EN): same data.
  - Windows expected: (44,11,22), (11,22,33), (22,33,44), (33,44,11).
  - 5 fetches per frame: 3,0,1,2,3.
- Reset mid-frame: assert rst during row 2.
  - All outputs 0 immediately, no frame_done.
  - A fresh start produces the full correct frame from row 0.
- start during busy: pulse start at row 1 -> ignored; frame completes normally with a single frame_done.
